// File: rtl/seq_detect_sched.sv
// Round-robin scheduler sharing one sequence detector among N_REQ serial-frame requesters.
// Optional abort path (abort / done_abort ports) is built when SEQ_SCHED_ABORT_EN is defined.
module seq_detect_sched #(
    parameter int N_REQ     = 4,
    parameter int LEN_W     = 8,
    parameter int DRAIN_CYC = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ*LEN_W-1:0]   req_len,
    input  logic [N_REQ-1:0]         req_bit,
    output logic [N_REQ-1:0]         gnt,
    output logic                     det_rst_n,
    output logic                     det_data,
    output logic                     det_data_valid,
    input  logic                     det_match,
`ifdef SEQ_SCHED_ABORT_EN
    input  logic                     abort,
    output logic                     done_abort,
`endif
    output logic                     done,
    output logic [$clog2(N_REQ)-1:0] done_id,
    output logic [LEN_W-1:0]         done_cnt
);
    localparam int IDW = $clog2(N_REQ);
    localparam int DW  = $clog2(DRAIN_CYC + 1);

    typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_SEND, S_DRAIN, S_REPORT} state_t;

    state_t           r_state;
    logic [IDW-1:0]   r_id;
    logic [IDW-1:0]   r_rr_ptr;
    logic [LEN_W-1:0] r_len;
    logic [LEN_W-1:0] r_bit_cnt;
    logic [DW-1:0]    r_drn_cnt;
    logic [LEN_W-1:0] r_cnt;
    logic             r_det_rst_n;
    logic             r_done;
    logic [IDW-1:0]   r_done_id;
    logic [LEN_W-1:0] r_done_cnt;
    logic             r_done_abort;

    logic             w_found;
    logic [IDW-1:0]   w_sel;
    logic [LEN_W-1:0] w_sel_len;
    int               w_j;
    logic             w_counting;
    logic [LEN_W-1:0] w_cnt_nxt;
    logic             w_abort;
    logic             w_go_report;

`ifdef SEQ_SCHED_ABORT_EN
    assign w_abort    = abort;
    assign done_abort = r_done_abort;
`else
    assign w_abort    = 1'b0;
`endif

    // First requester at or above rr_ptr, wrapping around.
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        w_j     = 0;
        for (int k = 0; k < N_REQ; k++) begin
            w_j = int'(r_rr_ptr) + k;
            if (w_j >= N_REQ) w_j = w_j - N_REQ;
            if (!w_found && req[w_j[IDW-1:0]]) begin
                w_found = 1'b1;
                w_sel   = w_j[IDW-1:0];
            end
        end
    end

    assign w_sel_len  = req_len[int'(w_sel)*LEN_W +: LEN_W];
    assign w_counting = (r_state == S_SEND) || (r_state == S_DRAIN);
    assign w_cnt_nxt  = (w_counting && det_match && (r_cnt != {LEN_W{1'b1}})) ?
                        r_cnt + LEN_W'(1) : r_cnt;

    always_comb begin
        w_go_report = 1'b0;
        case (r_state)
            S_IDLE:  w_go_report = w_found && (w_sel_len == '0);
            S_SEND:  w_go_report = w_abort;
            S_DRAIN: w_go_report = w_abort || (r_drn_cnt == DW'(DRAIN_CYC - 1));
            default: w_go_report = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_id         <= '0;
            r_rr_ptr     <= '0;
            r_len        <= '0;
            r_bit_cnt    <= '0;
            r_drn_cnt    <= '0;
            r_cnt        <= '0;
            r_det_rst_n  <= 1'b0;
            r_done       <= 1'b0;
            r_done_id    <= '0;
            r_done_cnt   <= '0;
            r_done_abort <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_det_rst_n <= 1'b1;
                    if (w_found) begin
                        r_id  <= w_sel;
                        r_len <= w_sel_len;
                        r_cnt <= '0;
                        if (w_sel_len == '0) begin
                            r_state <= S_REPORT;
                        end else begin
                            r_state     <= S_CLEAR;
                            r_det_rst_n <= 1'b0;
                        end
                    end
                end
                S_CLEAR: begin
                    r_det_rst_n <= 1'b1;
                    r_bit_cnt   <= '0;
                    r_state     <= S_SEND;
                end
                S_SEND: begin
                    r_cnt <= w_cnt_nxt;
                    if (w_abort) begin
                        r_state <= S_REPORT;
                    end else if (r_bit_cnt == r_len - LEN_W'(1)) begin
                        r_drn_cnt <= '0;
                        r_state   <= S_DRAIN;
                    end else begin
                        r_bit_cnt <= r_bit_cnt + LEN_W'(1);
                    end
                end
                S_DRAIN: begin
                    r_cnt <= w_cnt_nxt;
                    if (w_go_report) r_state   <= S_REPORT;
                    else             r_drn_cnt <= r_drn_cnt + DW'(1);
                end
                S_REPORT: begin
                    r_rr_ptr <= (r_id == IDW'(N_REQ - 1)) ? '0 : r_id + IDW'(1);
                    r_state  <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase

            // Result registers load on entry to REPORT so done and its payload align.
            if (w_go_report) begin
                r_done       <= 1'b1;
                r_done_id    <= (r_state == S_IDLE) ? w_sel : r_id;
                r_done_cnt   <= (r_state == S_IDLE) ? '0 : w_cnt_nxt;
                r_done_abort <= w_abort && (r_state != S_IDLE);
            end
        end
    end

    always_comb begin
        gnt            = '0;
        det_data       = 1'b0;
        det_data_valid = 1'b0;
        if (r_state == S_SEND) begin
            gnt[r_id]      = 1'b1;
            det_data       = req_bit[r_id];
            det_data_valid = 1'b1;
        end
    end

    assign det_rst_n = r_det_rst_n;
    assign done      = r_done;
    assign done_id   = r_done_id;
    assign done_cnt  = r_done_cnt;

endmodule

// File: tb/tb_seq_detect_sched.sv
// Scoreboard bench for seq_detect_sched: directed frames push expected results, a monitor checks done.
module tb_seq_detect_sched;
    localparam int N  = 4;
    localparam int LW = 8;
    localparam int DC = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req, req_bit, gnt;
    logic [N*LW-1:0] req_len;
    logic            det_rst_n, det_data, det_data_valid, det_match, done;
    logic [1:0]      done_id;
    logic [LW-1:0]   done_cnt;
`ifdef SEQ_SCHED_ABORT_EN
    logic            abort, done_abort;
`endif

    seq_detect_sched #(.N_REQ(N), .LEN_W(LW), .DRAIN_CYC(DC)) dut (
        .clk(clk), .rst(rst), .req(req), .req_len(req_len), .req_bit(req_bit),
        .gnt(gnt), .det_rst_n(det_rst_n), .det_data(det_data),
        .det_data_valid(det_data_valid), .det_match(det_match),
`ifdef SEQ_SCHED_ABORT_EN
        .abort(abort), .done_abort(done_abort),
`endif
        .done(done), .done_id(done_id), .done_cnt(done_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]    id;
        logic [LW-1:0] cnt;
        logic          ab;
    } exp_t;

    exp_t sb[$];
    exp_t m_e;
    int   vecs = 0;
    int   errs = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic push_exp(input int id, input int cnt, input bit ab);
        exp_t e;
        e.id  = id[1:0];
        e.cnt = cnt[LW-1:0];
        e.ab  = ab;
        sb.push_back(e);
    endtask

    task automatic set_len(input int id, input int len);
        req_len[id*LW +: LW] = len[LW-1:0];
    endtask

    // Monitor: every done strobe consumes one expected result.
    always @(negedge clk) begin
        if (!rst && done === 1'b1) begin
            if (sb.size() == 0) begin
                vecs++;
                errs++;
                $display("FAIL unexpected_done: got id=%0d cnt=%0d expected no done", done_id, done_cnt);
            end else begin
                m_e = sb.pop_front();
                chk("done_id", 32'(done_id), 32'(m_e.id));
                chk("done_cnt", 32'(done_cnt), 32'(m_e.cnt));
`ifdef SEQ_SCHED_ABORT_EN
                chk("done_abort", 32'(done_abort), 32'(m_e.ab));
`endif
            end
        end
    end

    // Called on a negedge; returns on the negedge of the REPORT cycle.
    task automatic frame(input int id, input int len, input logic [63:0] bits,
                         input logic [63:0] mm, input bit mall, input int exp_cnt,
                         input bit hold, input int exp_lat);
        int   w = 0;
        logic p0 = 1'b1, p1 = 1'b1;
        logic b, m;
        push_exp(id, exp_cnt, 1'b0);
        while (gnt == '0 && w < 20) begin
            p0 = p1;
            p1 = det_rst_n;
            @(negedge clk);
            w++;
        end
        if (gnt == '0) begin
            vecs++;
            errs++;
            $display("FAIL gnt_timeout: got no grant expected gnt[%0d]", id);
            return;
        end
        chk("clear_before_gnt", 32'(p1), 32'd0);
        if (exp_lat > 0) begin
            chk("grant_latency", w, exp_lat);
            chk("idle_before_clear", 32'(p0), 32'd1);
        end
        if (!hold) req[id] = 1'b0;
        for (int k = 0; k < len; k++) begin
            b = (k < 64) ? bits[k] : 1'b0;
            m = (k < 64) ? mm[k] : 1'b0;
            req_bit[id] = b;
            det_match   = mall | m;
            #1;
            chk("gnt", 32'(gnt), 32'(1) << id);
            chk("det_data", 32'(det_data), 32'(b));
            chk("det_valid", 32'(det_data_valid), 32'd1);
            @(negedge clk);
        end
        chk("gnt_after_send", 32'(gnt), 32'd0);
        chk("valid_after_send", 32'(det_data_valid), 32'd0);
        for (int d = 0; d < DC; d++) begin
            m = (len + d < 64) ? mm[len+d] : 1'b0;
            det_match = mall | m;
            @(negedge clk);
        end
        det_match = 1'b0;
        req_bit   = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int w;
        rst = 1'b1; req = '0; req_bit = '0; req_len = '0; det_match = 1'b0;
`ifdef SEQ_SCHED_ABORT_EN
        abort = 1'b0;
`endif
        repeat (3) @(negedge clk);
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_det_rst_n", 32'(det_rst_n), 32'd0);
        chk("rst_valid", 32'(det_data_valid), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_done_id", 32'(done_id), 32'd0);
        chk("rst_done_cnt", 32'(done_cnt), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Single frame: bits 1,1,0,0,1, match on 4th bit
        set_len(0, 5);
        req = 4'b0001;
        frame(0, 5, 64'h13, 64'h8, 1'b0, 1, 1'b0, 2);
        repeat (3) @(negedge clk);
        chk("done_cnt_hold", 32'(done_cnt), 32'd1);
        chk("done_low_after", 32'(done), 32'd0);

        // Zero length from requester 2
        set_len(2, 0);
        req = 4'b0100;
        push_exp(2, 0, 1'b0);
        w = 0;
        do begin
            @(negedge clk);
            w++;
            chk("zero_len_gnt", 32'(gnt), 32'd0);
            chk("zero_len_valid", 32'(det_data_valid), 32'd0);
        end while (done !== 1'b1 && w < 4);
        chk("zero_len_done", 32'(done), 32'd1);
        req = '0;
        @(negedge clk);

        // Reset mid-SEND of requester 3: no done, rr_ptr back to 0
        set_len(3, 5);
        req = 4'b1000;
        w = 0;
        while (gnt == '0 && w < 20) begin @(negedge clk); w++; end
        chk("rst_test_gnt", 32'(gnt), 32'b1000);
        req = '0;
        req_bit[3] = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_gnt", 32'(gnt), 32'd0);
        chk("midrst_det_rst_n", 32'(det_rst_n), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        rst = 1'b0;
        req_bit = '0;
        @(negedge clk);

        // Round robin, all held, len=2: order 0,1,2,3,0,1 then req=0011 -> 0
        for (int i = 0; i < N; i++) set_len(i, 2);
        req = 4'b1111;
        frame(0, 2, 64'h2, 64'h0, 1'b0, 0, 1'b1, 0);
        frame(1, 2, 64'h1, 64'h0, 1'b0, 0, 1'b1, 0);
        frame(2, 2, 64'h3, 64'h1, 1'b0, 1, 1'b1, 0);
        frame(3, 2, 64'h0, 64'h3, 1'b0, 2, 1'b1, 0);
        frame(0, 2, 64'h1, 64'h0, 1'b0, 0, 1'b1, 0);
        frame(1, 2, 64'h2, 64'h2, 1'b0, 1, 1'b1, 0);
        req = 4'b0011;
        frame(0, 2, 64'h3, 64'h0, 1'b0, 0, 1'b1, 0);
        req = '0;
        @(negedge clk);

        // Drain capture: match one cycle after the last bit, then both drain cycles
        set_len(1, 3);
        req = 4'b0010;
        frame(1, 3, 64'h5, 64'h8, 1'b0, 1, 1'b0, 0);
        @(negedge clk);
        req = 4'b0010;
        frame(1, 3, 64'h2, 64'h18, 1'b0, 2, 1'b0, 0);
        @(negedge clk);

        // Match held high: 7+2 counted, then 255+2 saturates at 255
        set_len(3, 7);
        req = 4'b1000;
        frame(3, 7, 64'h55, 64'h0, 1'b1, 9, 1'b0, 0);
        @(negedge clk);
        set_len(3, 255);
        req = 4'b1000;
        frame(3, 255, 64'h0, 64'h0, 1'b1, 255, 1'b0, 0);
        @(negedge clk);

`ifdef SEQ_SCHED_ABORT_EN
        // Abort on 3rd SEND cycle of len=8 with match held: 3 counted
        set_len(0, 8);
        req = 4'b0001;
        push_exp(0, 3, 1'b1);
        w = 0;
        while (gnt == '0 && w < 20) begin @(negedge clk); w++; end
        chk("abort_gnt", 32'(gnt), 32'b0001);
        req = '0;
        det_match = 1'b1;
        repeat (2) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        det_match = 1'b0;
        chk("abort_gnt_drop", 32'(gnt), 32'd0);
        chk("abort_done", 32'(done), 32'd1);
        @(negedge clk);
`endif

        repeat (5) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule

// File: doc/seq_detect_sched.md
Name: seq_detect_sched

Overview:
- Round-robin scheduler that shares one external `sequence_detect` instance between N_REQ serial-frame requesters.
- Grants one requester at a time and clears the detector before each frame.
- Streams the frame bits into the detector's `data`/`data_valid` inputs, counts `match` pulses, and reports a per-frame match count to the winner.
- Sits between the requester bit sources and the detector in the bit-stream datapath.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- LEN_W, 8, width of frame length and match count.
- DRAIN_CYC, 2, idle cycles after the last bit, so that a late registered `match` is still counted.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  N_REQ  per-requester frame request; level, sampled only in IDLE.
- req_len  input  N_REQ*LEN_W  frame length of requester i on [i*LEN_W +: LEN_W].
- req_bit  input  N_REQ  serial bit of requester i; must be valid every cycle `gnt[i]`=1.
- gnt  output  N_REQ  one-hot grant; high exactly during the SEND cycles of the granted frame.
- det_rst_n  output  1  active-low clear to the detector.
- det_data  output  1  bit to the detector.
- det_data_valid  output  1  valid to the detector.
- det_match  input  1  match pulse from the detector.
- done  output  1  one-cycle frame-complete strobe.
- done_id  output  $clog2(N_REQ)  requester index of the completed frame; valid with `done`.
- done_cnt  output  LEN_W  match count of the completed frame; valid with `done`.

Behaviour:
- Reset (rst=1 at a clock edge) applies from any state:
  - state=IDLE, rr_ptr=0.
  - gnt=0, det_rst_n=0, det_data=0, det_data_valid=0.
  - done=0, done_id=0, done_cnt=0.
  - The frame in progress is abandoned with no `done`.
- State IDLE:
  - det_rst_n=1.
  - If any `req` bit is set, select the first set bit searching from rr_ptr upward with wrap.
  - Latch id and len = req_len[id].
  - If len==0, go to REPORT with count 0. Otherwise go to CLEAR.
  - If no `req` bit is set, stay in IDLE.
- State CLEAR:
  - Lasts 1 cycle with det_rst_n=0. Then go to SEND.
- State SEND:
  - gnt[id]=1, det_data_valid=1, det_data=req_bit[id] (combinational pass-through).
  - bit_cnt counts 0..len-1.
  - On bit_cnt==len-1, go to DRAIN.
  - SEND lasts exactly len cycles.
- State DRAIN:
  - gnt=0, det_data_valid=0, det_data=0.
  - Lasts exactly DRAIN_CYC cycles. Then go to REPORT.
- Match counting:
  - In SEND and DRAIN, each clock with det_match=1 increments the count.
  - The count saturates at 2^LEN_W-1.
  - det_match is ignored in IDLE, CLEAR and REPORT.
- State REPORT:
  - Lasts 1 cycle: done=1, done_id=id, done_cnt=count.
  - rr_ptr = (id+1) mod N_REQ. Then go to IDLE.
  - done_cnt and done_id hold their values until the next REPORT.
- Latency from `req` seen in IDLE to first gnt: 2 cycles (IDLE, CLEAR).
- Frame turnaround: len + DRAIN_CYC + 3 cycles.
- Changes to `req` or `req_len` after latch are ignored until the next IDLE.
- A requester that still holds `req` after its `done` competes again; round-robin order guarantees the others are served first.
- Simultaneous requests are resolved strictly by rr_ptr order; no starvation.

Optional Feature:
- Macro: SEQ_SCHED_ABORT_EN.
- When defined:
  - Adds input `abort` (1 bit) and output `done_abort` (1 bit, reset 0).
  - `abort`=1 in SEND or DRAIN forces the next state to REPORT. gnt drops immediately on that following cycle.
  - REPORT then asserts done_abort=1 with the partial count.
  - done_abort=0 for normal completion.
  - `abort` is ignored in other states.
- When not defined: no `abort`/`done_abort` ports; frames always run to completion.

Test Plan:
- Single frame:
  - Stimulus: req=0001, len=5, bits 1,1,0,0,1; detector matches on the 4th bit.
  - Response: gnt[0] high for exactly 5 cycles; det_rst_n low for 1 cycle before them; done with done_id=0, done_cnt=1.
- Round-robin:
  - Stimulus: req=1111 held, all len=2.
  - Response: grants in order 0,1,2,3,0.
  - Stimulus: after id=1 done, req=0011.
  - Response: next grant goes to 0.
- Zero length:
  - Stimulus: req=0100, len=0.
  - Response: no gnt, no det_data_valid; done with done_id=2, done_cnt=0 two cycles after req.
- Drain capture:
  - Stimulus: det_match pulses 1 cycle after the last bit, DRAIN_CYC=2.
  - Response: counted, done_cnt=1.
- Saturation and reset:
  - Stimulus: LEN_W=3, det_match held high for len=7.
  - Response: done_cnt=7 (saturated, not wrapped).
  - Stimulus: rst=1 for 1 cycle mid-SEND.
  - Response: gnt=0 and det_rst_n=0 next cycle, no done, rr_ptr=0.
- Abort (SEQ_SCHED_ABORT_EN):
  - Stimulus: abort on the 3rd SEND cycle of a len=8 frame.
  - Response: done, done_abort=1, count reflects only matches seen up to the abort.
